// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle signals between fetch, decode and execute.
// valid/ready: a beat moves on a rising clk edge when valid && ready; the producer holds valid and the payload steady until that beat.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        is_lui;
  logic        is_i_type;
  logic        is_branch;
  logic [3:0]  alu_ops;
  logic [31:0] imm;
  logic        illegal;

  modport slave (
    input  in_valid, instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd_addr, rd_we,
           is_lui, is_i_type, is_branch, alu_ops, imm, illegal
  );

  modport master (
    output in_valid, instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd_addr, rd_we,
           is_lui, is_i_type, is_branch, alu_ops, imm, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32 subset decoder: one registered output bundle, single-entry pipeline stage
// with flush and a saturating count of accepted illegal instructions.
module decode_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    decode_stage_if.slave bus,
    output logic [15:0]  illegal_count
);

    logic        out_valid_q;
    logic [31:0] out_pc_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic        rd_we_q, is_lui_q, is_i_type_q, is_branch_q, illegal_q;
    logic [3:0]  alu_ops_q;
    logic [31:0] imm_q;
    logic [15:0] illegal_count_q;

    logic        d_lui, d_i_type, d_branch, d_illegal, d_writes, d_rd_we;
    logic [3:0]  d_alu;
    logic [31:0] d_imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        in_fire;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    always_comb begin
        d_lui     = 1'b0;
        d_i_type  = 1'b0;
        d_branch  = 1'b0;
        d_illegal = 1'b0;
        d_writes  = 1'b0;
        d_alu     = 4'b0000;
        d_imm     = 32'h0;
        case (opcode)
            7'b0110111: begin
                d_lui    = 1'b1;
                d_writes = 1'b1;
                d_imm    = {12'b0, bus.instr[31:12]};
            end
            7'b0010011: begin
                d_i_type = 1'b1;
                d_writes = 1'b1;
                d_imm    = {{20{bus.instr[31]}}, bus.instr[31:20]};
                case (funct3)
                    3'b000:  d_alu = 4'b0000;
                    3'b100:  d_alu = 4'b0010;
                    3'b010:  d_alu = 4'b1000;
                    3'b011:  d_alu = 4'b1011;
                    default: d_illegal = 1'b1;
                endcase
            end
            7'b1100011: begin
                d_branch = 1'b1;
                d_imm    = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                            bus.instr[11:8], 1'b0};
                case (funct3)
                    3'b000:  d_alu = 4'b0000;
                    3'b001:  d_alu = 4'b0001;
                    3'b100:  d_alu = 4'b0010;
                    3'b101:  d_alu = 4'b0011;
                    default: d_illegal = 1'b1;
                endcase
            end
            7'b0110011: begin
                d_writes = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: d_alu = 4'b0000;
                    10'b0100000_000: d_alu = 4'b0001;
                    10'b0000000_100: d_alu = 4'b0010;
                    10'b0000000_110: d_alu = 4'b0011;
                    10'b0000000_111: d_alu = 4'b0100;
                    10'b0000000_001: d_alu = 4'b0101;
                    10'b0000000_101: d_alu = 4'b0110;
                    10'b0000000_010: d_alu = 4'b1001;
                    10'b0000001_000: d_alu = 4'b1100;
                    10'b0000001_100: d_alu = 4'b1101;
                    default:         d_illegal = 1'b1;
                endcase
            end
            default: d_illegal = 1'b1;
        endcase
        // An illegal word must leave no side effects in execute.
        if (d_illegal) begin
            d_lui    = 1'b0;
            d_i_type = 1'b0;
            d_branch = 1'b0;
            d_writes = 1'b0;
            d_alu    = 4'b0000;
            d_imm    = 32'h0;
        end
    end

    assign d_rd_we      = d_writes && (bus.instr[11:7] != 5'd0);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_pc_q        <= 32'h0;
            rs1_q           <= 5'd0;
            rs2_q           <= 5'd0;
            rd_q            <= 5'd0;
            rd_we_q         <= 1'b0;
            is_lui_q        <= 1'b0;
            is_i_type_q     <= 1'b0;
            is_branch_q     <= 1'b0;
            alu_ops_q       <= 4'b0000;
            imm_q           <= 32'h0;
            illegal_q       <= 1'b0;
            illegal_count_q <= 16'h0;
        end else if (flush) begin
            // The killed word is never counted, even if it was illegal.
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= bus.in_pc;
            rs1_q       <= bus.instr[19:15];
            rs2_q       <= bus.instr[24:20];
            rd_q        <= bus.instr[11:7];
            rd_we_q     <= d_rd_we;
            is_lui_q    <= d_lui;
            is_i_type_q <= d_i_type;
            is_branch_q <= d_branch;
            alu_ops_q   <= d_alu;
            imm_q       <= d_imm;
            illegal_q   <= d_illegal;
            if (d_illegal && (illegal_count_q != 16'hFFFF))
                illegal_count_q <= illegal_count_q + 16'd1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.rs1_addr  = rs1_q;
    assign bus.rs2_addr  = rs2_q;
    assign bus.rd_addr   = rd_q;
    assign bus.rd_we     = rd_we_q;
    assign bus.is_lui    = is_lui_q;
    assign bus.is_i_type = is_i_type_q;
    assign bus.is_branch = is_branch_q;
    assign bus.alu_ops   = alu_ops_q;
    assign bus.imm       = imm_q;
    assign bus.illegal   = illegal_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a
// behavioural decode/handshake model with expected and observed bundle queues.
module tb_decode_stage;
  localparam int W = 88;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] illegal_count;

  decode_stage_if bus();

  decode_stage dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_mismatch = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_bundle = '0;
  int           m_count = 0;
  logic         m_in_ready;
  logic         m_accept;

  // Bundle layout: {pc, rs1, rs2, rd, rd_we, is_lui, is_i_type, is_branch, alu_ops, imm, illegal}
  function automatic logic [W-1:0] model_decode(input logic [31:0] w, input logic [31:0] pc);
    int alu;
    int b;
    logic lui, ity, br, legal, we;
    logic [31:0] imm;
    alu = -1; lui = 0; ity = 0; br = 0; imm = 0;
    case (w[6:0])
      7'h37: begin lui = 1; alu = 0; imm = w >> 12; end
      7'h13: begin
        ity = 1;
        imm = $signed(w) >>> 20;
        case (w[14:12])
          3'd0: alu = 0;
          3'd4: alu = 2;
          3'd2: alu = 8;
          3'd3: alu = 11;
          default: alu = -1;
        endcase
      end
      7'h63: begin
        br = 1;
        b = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        imm = b;
        case (w[14:12])
          3'd0: alu = 0;
          3'd1: alu = 1;
          3'd4: alu = 2;
          3'd5: alu = 3;
          default: alu = -1;
        endcase
      end
      7'h33: begin
        if (w[31:25] == 7'h00) begin
          case (w[14:12])
            3'd0: alu = 0;
            3'd4: alu = 2;
            3'd6: alu = 3;
            3'd7: alu = 4;
            3'd1: alu = 5;
            3'd5: alu = 6;
            3'd2: alu = 9;
            default: alu = -1;
          endcase
        end else if (w[31:25] == 7'h20 && w[14:12] == 3'd0) alu = 1;
        else if (w[31:25] == 7'h01 && w[14:12] == 3'd0) alu = 12;
        else if (w[31:25] == 7'h01 && w[14:12] == 3'd4) alu = 13;
      end
      default: alu = -1;
    endcase
    legal = (alu >= 0);
    if (!legal) begin lui = 0; ity = 0; br = 0; imm = 0; alu = 0; end
    we = legal && !br && (w[11:7] != 5'd0);
    return {pc, w[19:15], w[24:20], w[11:7], we, lui, ity, br, alu[3:0], imm, !legal};
  endfunction

  function automatic logic [W-1:0] dut_bundle();
    return {bus.out_pc, bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.rd_we, bus.is_lui,
            bus.is_i_type, bus.is_branch, bus.alu_ops, bus.imm, bus.illegal};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h63;
      3: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      4: ;
      default: begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
    endcase
    return w;
  endfunction

  // Reference handshake model and observation capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_count = 0;
    end else begin
      m_in_ready = !m_valid || bus.out_ready;
      if (bus.in_ready !== m_in_ready || bus.out_valid !== m_valid) hs_mismatch++;
      if (bus.out_valid && bus.out_ready) obs_q.push_back(dut_bundle());
      if (m_valid && bus.out_ready) exp_q.push_back(m_bundle);
      m_accept = bus.in_valid && m_in_ready;
      if (flush) m_valid = 1'b0;
      else if (m_accept) begin
        m_bundle = model_decode(bus.instr, bus.in_pc);
        m_valid  = 1'b1;
        if (m_bundle[0] && m_count < 65535) m_count++;
      end else if (m_valid && bus.out_ready) m_valid = 1'b0;
    end
  end

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.instr    = w;
    bus.in_pc    = pc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.instr = '0; bus.in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || illegal_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid=%b in_ready=%b count=%h, want 0 1 0000",
               bus.out_valid, bus.in_ready, illegal_count);
    end
    checks++;
    if (dut_bundle() !== '0) begin
      errors++;
      $display("FAIL reset_bundle: got %h, want 0", dut_bundle());
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    bus.out_ready = 1'b1;
    send(32'h00500093, 32'h100);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.is_i_type !== 1'b1 || bus.alu_ops !== 4'b0000 ||
        bus.imm !== 32'd5 || bus.rd_addr !== 5'd1 || bus.rd_we !== 1'b1) begin
      errors++;
      $display("FAIL addi: v=%b i=%b alu=%h imm=%h rd=%0d we=%b, want 1 1 0 5 1 1",
               bus.out_valid, bus.is_i_type, bus.alu_ops, bus.imm, bus.rd_addr, bus.rd_we);
    end
    drain();
  endtask

  task automatic test_branch_sub();
    bus.out_ready = 1'b1;
    send(32'hFE208EE3, 32'h200);
    checks++;
    if (bus.is_branch !== 1'b1 || bus.alu_ops !== 4'b0000 || bus.imm !== 32'hFFFFFFFC ||
        bus.rd_we !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL beq: br=%b alu=%h imm=%h we=%b ill=%b, want 1 0 fffffffc 0 0",
               bus.is_branch, bus.alu_ops, bus.imm, bus.rd_we, bus.illegal);
    end
    send(32'h40208033, 32'h204);
    checks++;
    if (bus.alu_ops !== 4'b0001 || bus.imm !== 32'h0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL sub: alu=%h imm=%h ill=%b, want 1 0 0", bus.alu_ops, bus.imm, bus.illegal);
    end
    drain();
  endtask

  task automatic test_lui();
    bus.out_ready = 1'b1;
    send(32'h123450B7, 32'h300);
    checks++;
    if (bus.is_lui !== 1'b1 || bus.imm !== 32'h00012345 || bus.alu_ops !== 4'b0000 ||
        bus.rd_we !== 1'b1) begin
      errors++;
      $display("FAIL lui_x1: lui=%b imm=%h alu=%h we=%b, want 1 00012345 0 1",
               bus.is_lui, bus.imm, bus.alu_ops, bus.rd_we);
    end
    send(32'h12345037, 32'h304);
    checks++;
    if (bus.is_lui !== 1'b1 || bus.rd_we !== 1'b0) begin
      errors++;
      $display("FAIL lui_x0: lui=%b we=%b, want 1 0", bus.is_lui, bus.rd_we);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    logic [W-1:0] want_b;
    exp_q.delete(); obs_q.delete();
    bus.out_ready = 1'b0;
    send(32'h00A00113, 32'h400);
    held = dut_bundle();
    bus.in_valid = 1'b1; bus.instr = 32'h002081B3; bus.in_pc = 32'h404;
    want_b = model_decode(32'h002081B3, 32'h404);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || dut_bundle() !== held) begin
        errors++;
        $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b bundle=%h, want 0 1 %h",
                 i, bus.in_ready, bus.out_valid, dut_bundle(), held);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || dut_bundle() !== want_b) begin
      errors++;
      $display("FAIL stall_release: valid=%b bundle=%h, want 1 %h", bus.out_valid, dut_bundle(), want_b);
    end
    drain();
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL stall_count: observed %0d expected-queue %0d, want 2 2", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] got, want;
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall_order: got %h, want %h", got, want);
      end
    end
  endtask

  task automatic test_flush();
    int c;
    bus.out_ready = 1'b1;
    c = int'(illegal_count);
    flush = 1'b1;
    send(32'hFFFFFFFF, 32'h500);
    flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || int'(illegal_count) != c) begin
      errors++;
      $display("FAIL flush_kill: valid=%b count=%0d, want 0 %0d", bus.out_valid, illegal_count, c);
    end
    send(32'hFFFFFFFF, 32'h504);
    checks++;
    if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b1 || int'(illegal_count) != c + 1 ||
        bus.rd_we !== 1'b0 || bus.imm !== 32'h0) begin
      errors++;
      $display("FAIL illegal_accept: ill=%b valid=%b count=%0d we=%b imm=%h, want 1 1 %0d 0 0",
               bus.illegal, bus.out_valid, illegal_count, bus.rd_we, bus.imm, c + 1);
    end
    drain();
  endtask

  task automatic test_random();
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      bus.instr     = gen_instr();
      bus.in_pc     = $urandom & 32'hFFFFFFFC;
      @(posedge clk); #1;
    end
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: observed %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] got, want;
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_bundle: got %h, want %h", got, want);
      end
    end
    checks++;
    if (int'(illegal_count) != m_count) begin
      errors++;
      $display("FAIL random_illegal_count: got %0d, want %0d", illegal_count, m_count);
    end
    checks++;
    if (hs_mismatch != 0) begin
      errors++;
      $display("FAIL handshake: %0d cycles disagreed with model, want 0", hs_mismatch);
    end
  endtask

  task automatic test_saturate_and_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'hFFFFFFFF;
    bus.in_pc     = 32'h600;
    repeat (65600) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_q.delete(); obs_q.delete();
    checks++;
    if (illegal_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate: count=%h, want ffff", illegal_count);
    end
    send(32'hFFFFFFFF, 32'h604);
    checks++;
    if (illegal_count !== 16'hFFFF || bus.illegal !== 1'b1) begin
      errors++;
      $display("FAIL saturate_hold: count=%h ill=%b, want ffff 1", illegal_count, bus.illegal);
    end
    drain();
    bus.out_ready = 1'b0;
    send(32'h00500093, 32'h700);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || illegal_count !== 16'h0 || bus.in_ready !== 1'b1 ||
        dut_bundle() !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b count=%h in_ready=%b bundle=%h, want 0 0 1 0",
               bus.out_valid, illegal_count, bus.in_ready, dut_bundle());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(32'h00500093, 32'h704);
    checks++;
    if (bus.out_valid !== 1'b1 || dut_bundle() !== model_decode(32'h00500093, 32'h704)) begin
      errors++;
      $display("FAIL post_reset: valid=%b bundle=%h, want 1 %h", bus.out_valid, dut_bundle(),
               model_decode(32'h00500093, 32'h704));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch_sub();
    test_lui();
    test_stall();
    test_flush();
    test_random();
    test_saturate_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports: clk in 1, clock, all state on rising edge.
REQ-002 SHALL have: rst in 1, asynchronous active-high reset.
REQ-003 SHALL have: in_valid in 1, fetch offers instr/in_pc.
REQ-004 SHALL have: in_ready out 1, stage accepts input.
REQ-005 SHALL have: instr in 32, raw RV32 instruction word.
REQ-006 SHALL have: in_pc in 32, address of instr.
REQ-007 SHALL have: flush in 1, taken-branch kill (driven from ALU pc_load).
REQ-008 SHALL have: out_valid out 1, decoded bundle valid.
REQ-009 SHALL have: out_ready in 1, execute consumes bundle.
REQ-010 SHALL have: out_pc out 32; rs1_addr, rs2_addr, rd_addr out 5 each; rd_we out 1.
REQ-011 SHALL have: is_lui, is_i_type, is_branch out 1 each; alu_ops out 4; imm out 32.
REQ-012 SHALL have: illegal out 1, bundle is an unsupported instruction; illegal_count out 16, saturating count of accepted illegal instructions.

Function
REQ-013 SHALL register all bundle outputs in one output register; latency instr->out_valid exactly 1 cycle.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (combinational); transfer in when in_valid && in_ready; out when out_valid && out_ready.
REQ-015 SHALL hold every bundle output stable while out_valid && !out_ready.
REQ-016 SHALL, on out-transfer without in-transfer, clear out_valid next cycle; back-to-back transfers sustain 1 instr/cycle.
REQ-017 SHALL, when flush=1, clear out_valid next cycle and discard any input accepted that cycle (flush wins over in_valid; no illegal_count increment).
REQ-018 SHALL decode LUI (opcode 0110111): is_lui=1, imm = {12'b0, instr[31:12]} (execute shifts by 12), alu_ops=0000.
REQ-019 SHALL decode OP-IMM (0010011): is_i_type=1, imm = sign-extended instr[31:20]; funct3 000->0000, 100->0010, 010->1000, 011->1011; other funct3 illegal.
REQ-020 SHALL decode BRANCH (1100011): is_branch=1, rd_we=0, imm = sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; funct3 000->0000, 001->0001, 100->0010, 101->0011; others illegal.
REQ-021 SHALL decode OP (0110011), {funct7,funct3}: 0000000/000->0000, 0100000/000->0001, 0000000/100->0010, /110->0011, /111->0100, /001->0101, /101->0110, /010->1001, 0000001/000->1100, 0000001/100->1101; imm=0; others illegal.
REQ-022 SHALL set rs1_addr=instr[19:15], rs2_addr=instr[24:20], rd_addr=instr[11:7] for every instruction.
REQ-023 SHALL set rd_we=1 for legal LUI/OP-IMM/OP only when rd_addr!=0.
REQ-024 SHALL, for illegal instructions (any other opcode or funct): illegal=1, rd_we=0, is_* =0, alu_ops=0000, imm=0.
REQ-025 SHALL increment illegal_count by 1 per accepted, non-flushed illegal instruction; saturate at 0xFFFF.
REQ-026 SHALL keep at most one bundle in flight; no internal queue.

Reset
REQ-027 SHALL, on rst=1 asynchronously: out_valid=0, illegal_count=0, all bundle outputs 0, in_ready=1.
REQ-028 SHALL, on rst asserted mid-stall, drop the held bundle; first post-reset accept decodes normally.

Verification
REQ-029 Reset then instr=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, is_i_type=1, alu_ops=0000, imm=5, rd_addr=1, rd_we=1.
REQ-030 instr=0xFE208EE3 (beq x1,x2,-4) -> is_branch=1, alu_ops=0000, imm=0xFFFFFFFC, rd_we=0; 0x40208033 (sub) -> alu_ops=0001.
REQ-031 instr=0x123450B7 (lui x1) -> is_lui=1, imm=0x00012345; same with rd=0 -> rd_we=0.
REQ-032 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle unchanged; out_ready=1 -> next instr appears one cycle later, none lost or duplicated.
REQ-033 flush=1 coincident with in_valid=1 and illegal instr 0xFFFFFFFF -> out_valid=0 next cycle, illegal_count unchanged; same instr without flush -> illegal=1, illegal_count+1.
REQ-034 Preload 65535 illegal instrs, send one more -> illegal_count stays 0xFFFF; assert rst mid-stall -> out_valid=0, count=0 immediately.
